// File: rtl/spi_rd_fifo.sv
// spi_rd_fifo: show-ahead synchronous FIFO feeding the SPI read slave's inport.
// The head word is registered on rd_data. A one-cycle clr from the slave pops the FIFO.
// Optional macro FIFO_EMPTY_MARK_EN: while empty, rd_data shows EMPTY_CODE instead of
// the stale last-popped word.
module spi_rd_fifo #(
   parameter int unsigned     WIDTH      = 8,
   parameter int unsigned     AW         = 4,
   parameter logic [WIDTH-1:0] EMPTY_CODE = WIDTH'(8'hFF)
) (
   input  logic             clk240,
   input  logic             rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   input  logic             clr,
   input  logic             err_clr,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      level,
   output logic             ovf,
   output logic             udf
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned LW    = AW + 1;

`ifdef FIFO_EMPTY_MARK_EN
   localparam logic [WIDTH-1:0] RD_RESET = EMPTY_CODE;
`else
   localparam logic [WIDTH-1:0] RD_RESET = '0;
`endif

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   logic             push_ok;
   logic             pop_ok;
   logic [AW:0]      level_nxt;
   logic             ovf_nxt;
   logic             udf_nxt;
   logic [WIDTH-1:0] rd_nxt;

   // Accept/reject decisions, next level, sticky flags and next head word.
   always_comb begin
      push_ok   = 1'b0;
      pop_ok    = 1'b0;
      level_nxt = level;
      ovf_nxt   = ovf & ~err_clr;
      udf_nxt   = udf & ~err_clr;
      rd_nxt    = rd_data;

      // A pop on a full FIFO frees a slot in the same cycle, so the push still fits.
      push_ok = wr_en & (~full | clr);
      pop_ok  = clr & ~empty;

      if (push_ok && !pop_ok) begin
         level_nxt = level + LW'(1);
      end else if (pop_ok && !push_ok) begin
         level_nxt = level - LW'(1);
      end

      // Setting a flag wins over err_clr in the same cycle.
      if (wr_en && full && !clr) begin
         ovf_nxt = 1'b1;
      end
      if (clr && empty) begin
         udf_nxt = 1'b1;
      end

`ifdef FIFO_EMPTY_MARK_EN
      // Marker tracks empty with the same registered timing; the head word shows
      // one cycle after the first write, once memory holds it.
      if (empty || (level_nxt == '0)) begin
         rd_nxt = EMPTY_CODE;
      end else begin
         rd_nxt = mem[rd_ptr];
      end
`else
      // While empty, hold the last word presented instead of reading an unwritten slot.
      if (!empty) begin
         rd_nxt = mem[rd_ptr];
      end
`endif
   end

   // Control state: pointers, level, flags and registered head word.
   always_ff @(posedge clk240) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         empty   <= 1'b1;
         full    <= 1'b0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         rd_data <= RD_RESET;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level   <= level_nxt;
         empty   <= (level_nxt == '0);
         full    <= (level_nxt == LW'(DEPTH));
         ovf     <= ovf_nxt;
         udf     <= udf_nxt;
         rd_data <= rd_nxt;
      end
   end

   // Storage array; contents survive reset, and writes are blocked while reset is held.
   always_ff @(posedge clk240) begin
      if (!rst && push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_spi_rd_fifo.sv
// tb_spi_rd_fifo: randomized and directed stimulus for spi_rd_fifo.
// A queue-based reference model is compared with the DUT every cycle, and literal checks pin key points.
module tb_spi_rd_fifo;

`ifdef FIFO_EMPTY_MARK_EN
   localparam logic [7:0] RD_RESET = 8'hFF;
`else
   localparam logic [7:0] RD_RESET = 8'h00;
`endif

   logic       clk240 = 1'b0;
   logic       rst;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       clr;
   logic       err_clr;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [4:0] level;
   logic       ovf;
   logic       udf;

   int n_cmp = 0;
   int n_bad = 0;

   spi_rd_fifo #(.WIDTH(8), .AW(4), .EMPTY_CODE(8'hFF)) dut (
      .clk240  (clk240),
      .rst     (rst),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .clr     (clr),
      .err_clr (err_clr),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .level   (level),
      .ovf     (ovf),
      .udf     (udf)
   );

   always #5 clk240 = ~clk240;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO as a queue of words plus the word presented to the slave.
   logic [7:0] q[$];
   logic [7:0] m_rd;
   bit         m_ovf;
   bit         m_udf;
   bit         m_valid = 1'b0;

   always @(posedge clk240) begin
      int pre;
      bit push_ok;
      bit pop_ok;
      if (rst) begin
         q.delete();
         m_rd    = RD_RESET;
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         pre     = q.size();
         pop_ok  = clr && (pre > 0);
         push_ok = wr_en && ((pre < 16) || clr);
         // The word shown after this edge is the head as it stood before the edge.
         if (pre > 0) m_rd = q[0];
`ifdef FIFO_EMPTY_MARK_EN
         else m_rd = 8'hFF;
`endif
         if (pop_ok)  void'(q.pop_front());
         if (push_ok) q.push_back(wr_data);
`ifdef FIFO_EMPTY_MARK_EN
         if (q.size() == 0) m_rd = 8'hFF;
`endif
         if (wr_en && (pre == 16) && !clr) m_ovf = 1'b1;
         else if (err_clr)                 m_ovf = 1'b0;
         if (clr && (pre == 0))            m_udf = 1'b1;
         else if (err_clr)                 m_udf = 1'b0;
      end
   end

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk240) begin
      if (m_valid) begin
         check("level",   int'(level),   q.size());
         check("empty",   int'(empty),   int'(q.size() == 0));
         check("full",    int'(full),    int'(q.size() == 16));
         check("ovf",     int'(ovf),     int'(m_ovf));
         check("udf",     int'(udf),     int'(m_udf));
         check("rd_data", int'(rd_data), int'(m_rd));
      end
   end

   task automatic step(input bit we, input logic [7:0] wd, input bit cl, input bit ec);
      wr_en   = we;
      wr_data = wd;
      clr     = cl;
      err_clr = ec;
      @(posedge clk240);
      #1;
      wr_en   = 1'b0;
      clr     = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk240);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; clr = 1'b0; err_clr = 1'b0; wr_data = '0;
      @(posedge clk240); #1;
      do_reset();
      check("rst_level", int'(level), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_rd",    int'(rd_data), int'(RD_RESET));

      // Three pushes and three pops.
      step(1, 8'h11, 0, 0);
      check("t1_empty_after_push", int'(empty), 0);
      step(1, 8'h22, 0, 0);
      check("t1_fallthrough", int'(rd_data), 8'h11);
      step(1, 8'h33, 0, 0);
      check("t1_level3", int'(level), 3);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("t1_rd_22", int'(rd_data), 8'h22);
      step(0, 0, 1, 0);
      check("t1_empty", int'(empty), 1);
      step(0, 0, 0, 0);

      // Fill to full, overflow, then drain.
      for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
      check("t2_full",  int'(full),  1);
      check("t2_level", int'(level), 16);
      step(1, 8'hAA, 0, 0);
      check("t2_ovf",       int'(ovf),   1);
      check("t2_level_ovf", int'(level), 16);
      step(0, 0, 0, 1);
      check("t2_ovf_clr", int'(ovf), 0);
      for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("t2_drained", int'(empty), 1);

      // Simultaneous push and pop while full.
      for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
      step(1, 8'h55, 1, 0);
      check("t3_level16", int'(level), 16);
      check("t3_no_ovf",  int'(ovf),   0);
      for (int i = 0; i < 15; i++) step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      check("t3_last_55", int'(rd_data), 8'h55);
      step(0, 0, 1, 0);

      // Underflow, error clear, and push+pop while empty.
      step(0, 0, 1, 0);
      check("t4_udf",   int'(udf),   1);
      check("t4_level", int'(level), 0);
      step(0, 0, 0, 1);
      check("t4_udf_clr", int'(udf), 0);
      step(1, 8'h77, 1, 0);
      check("t4_level1", int'(level), 1);
      check("t4_udf2",   int'(udf),   1);
      step(0, 0, 0, 0);
      check("t4_rd_77", int'(rd_data), 8'h77);
      step(0, 0, 1, 1);

      // Random traffic with pointer wraps; the model checks order and level every cycle.
      for (int i = 0; i < 40; i++)
         step(bit'($urandom_range(0, 2) != 0), 8'($urandom), bit'($urandom_range(0, 2) == 0), 0);
      for (int i = 0; i < 600; i++)
         step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 7) == 0));

      // Reset while holding five words, with push and pop asserted on the reset edge.
      for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
      check("t5_level5", int'(level), 5);
      rst = 1'b1;
      step(1, 8'hEE, 1, 0);
      rst = 1'b0;
      check("t5_rst_level", int'(level), 0);
      check("t5_rst_empty", int'(empty), 1);

      // Behaviour of the empty marker.
      do_reset();
      check("t6_rst_rd", int'(rd_data), int'(RD_RESET));
      step(1, 8'h3C, 0, 0);
      step(0, 0, 0, 0);
      check("t6_rd_3c", int'(rd_data), 8'h3C);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
`ifdef FIFO_EMPTY_MARK_EN
      check("t6_after_pop", int'(rd_data), 8'hFF);
`else
      check("t6_after_pop", int'(rd_data), 8'h3C);
`endif
      step(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
